comp_16_seq: RTL and testbench



---
 rtl/comp_pkg.sv | 20 ++
 rtl/comp_16_seq_if.sv | 23 ++
 rtl/comp_4.sv | 18 +
 rtl/comp_16_seq.sv | 129 ++++++++++++
 tb/tb_comp_16_seq.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/comp_pkg.sv
// Shared types and sizing helpers for the sequential nibble-serial comparator.
package comp_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    function automatic int nibbles(input int width);
        return width / NIB_W;
    endfunction

    // Index counter width; a single-nibble build still needs one bit.
    function automatic int idx_bits(input int width);
        return (nibbles(width) > 1) ? $clog2(nibbles(width)) : 1;
    endfunction

endpackage

// File: rtl/comp_16_seq_if.sv
// Start/done handshake and result bus of the sequential comparator.
interface comp_16_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             out_A_G_B;
    logic             out_A_E_B;
    logic             out_A_L_B;

    modport master (
        output start, A, B,
        input  busy, done, out_A_G_B, out_A_E_B, out_A_L_B
    );

    modport slave (
        input  start, A, B,
        output busy, done, out_A_G_B, out_A_E_B, out_A_L_B
    );
endinterface

// File: rtl/comp_4.sv
// 4-bit magnitude compare slice cascaded from the more significant side:
// an already-decided upstream result passes through, otherwise this nibble decides.
module comp_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       gt_in,
    input  logic       eq_in,
    input  logic       lt_in,
    output logic       gt_out,
    output logic       eq_out,
    output logic       lt_out
);

    assign gt_out = gt_in | (eq_in & (a > b));
    assign eq_out = eq_in & (a == b);
    assign lt_out = lt_in | (eq_in & (a < b));

endmodule

// File: rtl/comp_16_seq.sv
// Sequential unsigned magnitude comparator: one comp_4 slice walks the operand
// nibbles MSB first, carrying the G/E/L cascade in registers between cycles.
module comp_16_seq
    import comp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    comp_16_seq_if.slave       bus
);

    // WIDTH is expected to be a multiple of NIB_W and at least NIB_W.
    localparam int               NIBBLES  = nibbles(WIDTH);
    localparam int               IDX_W    = idx_bits(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               g_q, g_d;
    logic               e_q, e_d;
    logic               l_q, l_d;
    logic               done_q, done_d;
    logic               res_g_q, res_g_d;
    logic               res_e_q, res_e_d;
    logic               res_l_q, res_l_d;

    logic [NIB_W-1:0]   a_nib [NIBBLES];
    logic [NIB_W-1:0]   b_nib [NIBBLES];
    logic               slice_g, slice_e, slice_l;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_q[gi*NIB_W +: NIB_W];
        assign b_nib[gi] = b_q[gi*NIB_W +: NIB_W];
    end

    comp_4 u_slice (
        .a      (a_nib[idx_q]),
        .b      (b_nib[idx_q]),
        .gt_in  (g_q),
        .eq_in  (e_q),
        .lt_in  (l_q),
        .gt_out (slice_g),
        .eq_out (slice_e),
        .lt_out (slice_l)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        done_d  = 1'b0;
        res_g_d = res_g_q;
        res_e_d = res_e_q;
        res_l_d = res_l_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    idx_d   = IDX_LAST;
                    state_d = CMP;
                end
            end
            CMP: begin
                g_d   = slice_g;
                e_d   = slice_e;
                l_d   = slice_l;
                idx_d = idx_q - 1'b1;
                // Once a nibble differs the cascade can no longer change.
                if ((idx_q == '0) || (EARLY_EXIT && !slice_e)) begin
                    res_g_d = slice_g;
                    res_e_d = slice_e;
                    res_l_d = slice_l;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            g_q     <= 1'b0;
            e_q     <= 1'b1;
            l_q     <= 1'b0;
            done_q  <= 1'b0;
            res_g_q <= 1'b0;
            res_e_q <= 1'b0;
            res_l_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            done_q  <= done_d;
            res_g_q <= res_g_d;
            res_e_q <= res_e_d;
            res_l_q <= res_l_d;
        end
    end

    assign bus.busy      = (state_q == CMP);
    assign bus.done      = done_q;
    assign bus.out_A_G_B = res_g_q;
    assign bus.out_A_E_B = res_e_q;
    assign bus.out_A_L_B = res_l_q;

endmodule

// File: tb/tb_comp_16_seq.sv
// Bench for comp_16_seq: a fixed-latency and an early-exit instance share clock and reset.
module tb_comp_16_seq;

    logic clk;
    logic rst_n;

    comp_16_seq_if #(.WIDTH(16)) bus0 ();
    comp_16_seq_if #(.WIDTH(16)) bus1 ();

    comp_16_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    comp_16_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       n_checks = 0;
    int       n_pass   = 0;
    int       n_txn    = 0;
    logic [2:0] prev_res [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic get_busy(input bit ee);
        return ee ? bus1.busy : bus0.busy;
    endfunction

    function automatic logic get_done(input bit ee);
        return ee ? bus1.done : bus0.done;
    endfunction

    function automatic logic [2:0] get_res(input bit ee);
        return ee ? {bus1.out_A_G_B, bus1.out_A_E_B, bus1.out_A_L_B}
                  : {bus0.out_A_G_B, bus0.out_A_E_B, bus0.out_A_L_B};
    endfunction

    task automatic drive(input bit ee, input logic s, input logic [15:0] a, input logic [15:0] b);
        if (ee) begin
            bus1.start = s; bus1.A = a; bus1.B = b;
        end else begin
            bus0.start = s; bus0.A = a; bus0.B = b;
        end
    endtask

    function automatic logic [2:0] ref_res(input logic [15:0] a, input logic [15:0] b);
        return {a > b, a == b, a < b};
    endfunction

    function automatic int ref_lat(input bit ee, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        if (!ee) return 4;
        x = a ^ b;
        if (x[15:12] != 0) return 1;
        if (x[11:8]  != 0) return 2;
        if (x[7:4]   != 0) return 3;
        return 4;
    endfunction

    // Starts a compare, holds start high with scrambled operands while busy,
    // and leaves time at the done cycle (+1) so a following call is back-to-back.
    task automatic do_cmp(input bit ee, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] exp_res, input int exp_lat, input string tag);
        int lat;
        bit busy_ok;
        bit hold_ok;
        drive(ee, 1'b1, a, b);
        @(posedge clk); #1;
        chk({tag, ":busy_t0"}, 32'(get_busy(ee)), 32'd1);
        drive(ee, 1'b1, ~a, ~b);
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!get_done(ee) && lat < 20) begin
            if (!get_busy(ee)) busy_ok = 1'b0;
            if (get_res(ee) !== prev_res[ee]) hold_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        drive(ee, 1'b0, a, b);
        chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ":result"}, 32'(get_res(ee)), 32'(exp_res));
        chk({tag, ":busy_during"}, 32'(busy_ok), 32'd1);
        chk({tag, ":out_hold"}, 32'(hold_ok), 32'd1);
        chk({tag, ":busy_done"}, 32'({get_busy(ee), get_done(ee)}), 32'b01);
        prev_res[ee] = exp_res;
        n_txn++;
        $display("txn %0d %s ee=%0d A=%h B=%h res=%b lat=%0d", n_txn, tag, ee, a, b, get_res(ee), lat);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          mode;
        bit          no_done;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        prev_res[0] = 3'b000;
        prev_res[1] = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            chk("idle_ee0", 32'({bus0.busy, bus0.done, get_res(1'b0)}), 32'd0);
            chk("idle_ee1", 32'({bus1.busy, bus1.done, get_res(1'b1)}), 32'd0);
            @(posedge clk); #1;
        end

        do_cmp(1'b0, 16'h1234, 16'h1235, 3'b001, 4, "lt_fixed");
        @(posedge clk); #1;
        do_cmp(1'b1, 16'h8000, 16'h7FFF, 3'b100, 1, "gt_early");
        @(posedge clk); #1;
        do_cmp(1'b1, 16'hBEEF, 16'hBEEF, 3'b010, 4, "eq_early");

        do_cmp(1'b1, 16'h1234, 16'h1200, 3'b100, 3, "b2b_first_ee1");
        do_cmp(1'b1, 16'h0001, 16'h0000, 3'b100, 4, "b2b_second_ee1");
        do_cmp(1'b0, 16'h5000, 16'h6000, 3'b001, 4, "b2b_first_ee0");
        do_cmp(1'b0, 16'h0001, 16'h0000, 3'b100, 4, "b2b_second_ee0");
        @(posedge clk); #1;

        // Abort a fixed-latency compare two cycles in.
        drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort:busy_before", 32'(bus0.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort:state", 32'({bus0.busy, bus0.done, get_res(1'b0)}), 32'd0);
        prev_res[0] = 3'b000;
        prev_res[1] = 3'b000;
        no_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus0.done || bus0.busy) no_done = 1'b0;
            @(posedge clk); #1;
        end
        chk("abort:no_done", 32'(no_done), 32'd1);
        do_cmp(1'b0, 16'hFFFF, 16'h0000, 3'b100, 4, "after_abort");
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = ra;
            mode = $urandom_range(0, 5);
            if (mode >= 1 && mode <= 4)
                rb[(mode-1)*4 +: 4] = 4'($urandom);
            else if (mode == 5)
                rb = 16'($urandom);
            do_cmp(1'b0, ra, rb, ref_res(ra, rb), ref_lat(1'b0, ra, rb), "rand");
            do_cmp(1'b1, ra, rb, ref_res(ra, rb), ref_lat(1'b1, ra, rb), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
